// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-pass shift sequencer: FSM states,
// the largest step the external shifter can take per pass, and a helper
// that picks the step size for a given remaining shift amount.
package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned MAX_STEP = 3;

   // Largest legal step not exceeding the remaining amount, so the
   // remaining count can never wrap below zero.
   function automatic logic [1:0] step_of(input int unsigned rem);
      if (rem >= MAX_STEP) begin
         return 2'(MAX_STEP);
      end
      return 2'(rem);
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between a requester (master) and the
// shift sequencer (slave).
import shift_sequencer_pkg::*;

interface shift_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 4
) ();

   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] data_in;
   logic [AMT_W-1:0] amount;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;

   modport master (
      output start_valid,
      output data_in,
      output amount,
      output res_ready,
      input  start_ready,
      input  res_valid,
      input  res_data
   );

   modport slave (
      input  start_valid,
      input  data_in,
      input  amount,
      input  res_ready,
      output start_ready,
      output res_valid,
      output res_data
   );

endinterface

// File: rtl/shift_sequencer.sv
// Multi-pass controller around an external 4-bit logical-right shifter.
// Each SHIFT cycle presents the running value and a step of 0..3 to the
// shifter and captures its combinational output as the next running value.
// The result is offered one cycle after the last pass and held until taken.
import shift_sequencer_pkg::*;

module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_sequencer_if.slave bus,
   output logic             busy,
   output logic [WIDTH-1:0] sh_a,
   output logic [1:0]       sh_sel,
   input  logic [WIDTH-1:0] sh_out
);

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [AMT_W-1:0] rem_q;
   logic [AMT_W-1:0] rem_next;
   logic [1:0]       sel_q;
   logic             res_valid_q;
   logic [WIDTH-1:0] res_data_q;
   logic             in_idle;

   // The illegal encoding 2'd3 behaves exactly like IDLE.
   assign in_idle  = (state != SHIFT) && (state != DONE);

   assign rem_next = rem_q - AMT_W'(sel_q);

   assign sh_a            = data_q;
   assign sh_sel          = sel_q;
   assign busy            = !in_idle;
   assign bus.start_ready = rst_n && in_idle;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;

   // Sequencer FSM: accept, run one shifter pass per clock, then offer the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         data_q      <= '0;
         rem_q       <= '0;
         sel_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         case (state)
            SHIFT: begin
               data_q <= sh_out;
               rem_q  <= rem_next;
               if (rem_next == '0) begin
                  state <= DONE;
                  sel_q <= '0;
               end else begin
                  sel_q <= step_of(32'(rem_next));
               end
            end
            DONE: begin
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= data_q;
               end else if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               sel_q       <= '0;
               res_valid_q <= 1'b0;
               if (bus.start_valid) begin
                  data_q <= bus.data_in;
                  rem_q  <= bus.amount;
                  if (bus.amount == '0) begin
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                     sel_q <= step_of(32'(bus.amount));
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes the hand-computed
// result and latency of each accepted request; a monitor compares whenever
// the sequencer presents a result. A behavioural shifter closes the loop.
module tb_shift_sequencer;

   localparam int WIDTH = 4;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             busy;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_out;
   logic [1:0]       sh_sel;

   shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .busy   (busy),
      .sh_a   (sh_a),
      .sh_sel (sh_sel),
      .sh_out (sh_out)
   );

   assign sh_out = sh_a >> sh_sel;

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   bit   seenValid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: check latency on the first valid cycle, data on every valid cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         seenValid = 1'b0;
      end else if (bus.res_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_res_valid", int'(bus.res_valid), 0);
         end else begin
            if (!seenValid) begin
               seenValid = 1'b1;
               checkOutput("latency", cyc - sb[0].acc, sb[0].lat);
            end
            checkOutput("res_data", int'(bus.res_data), int'(sb[0].data));
            if (bus.res_ready) begin
               void'(sb.pop_front());
               seenValid = 1'b0;
            end
         end
      end
   end

   // Issue one request; returns at accept edge +#1, or after the pass checks.
   task automatic applyStimulus(input logic [3:0] d, input logic [3:0] amt,
                                input logic [3:0] expData, input int expLat,
                                input bit checkPasses);
      int         k = 0;
      bit         ready = 1'b0;
      logic [3:0] cur = d;
      int         rem = int'(amt);
      int         s;
      bus.data_in     = d;
      bus.amount      = amt;
      bus.start_valid = 1'b1;
      while (!ready && k < 20) begin
         @(negedge clk);
         ready = bus.start_ready;
         @(posedge clk);
         #1;
         k++;
      end
      bus.start_valid = 1'b0;
      if (!ready) begin
         checkOutput("accept_timeout", int'(ready), 1);
         return;
      end
      sb.push_back('{expData, expLat, cyc});
      if (checkPasses) begin
         while (rem > 0) begin
            s = (rem >= 3) ? 3 : rem;
            @(negedge clk);
            checkOutput("sh_sel", int'(sh_sel), s);
            checkOutput("sh_a", int'(sh_a), int'(cur));
            cur = cur >> s;
            rem = rem - s;
         end
      end
   endtask

   task automatic waitDone(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (sb.size() != 0) begin
         checkOutput("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;

      // Reset with a request already pending: it must not be taken.
      rst_n           = 1'b0;
      bus.start_valid = 1'b1;
      bus.data_in     = 4'b1011;
      bus.amount      = 4'd5;
      bus.res_ready   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_start_ready", int'(bus.start_ready), 0);
      @(posedge clk);
      #1;
      rst_n           = 1'b1;
      bus.start_valid = 1'b0;
      @(negedge clk);
      checkOutput("reset_start_ready_after", int'(bus.start_ready), 1);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_res_valid", int'(bus.res_valid), 0);
      checkOutput("reset_res_data", int'(bus.res_data), 0);
      checkOutput("reset_sh_a", int'(sh_a), 0);
      checkOutput("reset_sh_sel", int'(sh_sel), 0);
      @(posedge clk);
      #1;

      // Directed vectors with hand-computed results and latencies.
      applyStimulus(4'b1011, 4'd0,  4'b1011, 1, 1'b1);
      waitDone(20);
      applyStimulus(4'b1011, 4'd2,  4'b0010, 2, 1'b1);
      waitDone(20);
      applyStimulus(4'b1000, 4'd4,  4'b0000, 3, 1'b1);
      waitDone(20);
      applyStimulus(4'b1111, 4'd15, 4'b0000, 6, 1'b1);
      waitDone(20);

      // Backpressure: result held, new starts ignored while DONE.
      bus.res_ready = 1'b0;
      applyStimulus(4'b1100, 4'd1, 4'b0110, 2, 1'b1);
      k = 0;
      while (!bus.res_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         bus.start_valid = i[0];
         bus.data_in     = 4'b0001;
         bus.amount      = 4'd2;
         @(negedge clk);
         checkOutput("bp_start_ready", int'(bus.start_ready), 0);
         checkOutput("bp_res_valid", int'(bus.res_valid), 1);
         @(posedge clk);
         #1;
      end
      bus.start_valid = 1'b0;
      bus.res_ready   = 1'b1;
      waitDone(20);
      @(negedge clk);
      checkOutput("bp_release_start_ready", int'(bus.start_ready), 1);
      checkOutput("bp_release_res_valid", int'(bus.res_valid), 0);
      checkOutput("bp_release_busy", int'(busy), 0);
      @(posedge clk);
      #1;

      // Reset during the second pass of a 9-bit shift.
      applyStimulus(4'b1111, 4'd9, 4'b0000, 4, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("abort_pass2_sel", int'(sh_sel), 3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      @(negedge clk);
      checkOutput("abort_res_valid", int'(bus.res_valid), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_data_q", int'(sh_a), 0);
      checkOutput("abort_sh_sel", int'(sh_sel), 0);
      checkOutput("abort_start_ready", int'(bus.start_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(4'b1010, 4'd1, 4'b0101, 2, 1'b1);
      waitDone(20);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
